udp_tx_csum_engine: RTL

UDP_TX_CSUM_ENGINE -- requirements
Module: udp_tx_csum_engine

---
 rtl/udp_tx_csum_engine_pkg.sv | 28 ++
 rtl/udp_payload_fifo.sv | 62 ++++++
 rtl/udp_tx_csum_engine.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/udp_tx_csum_engine_pkg.sv
// Shared definitions for the UDP transmit checksum engine: FSM states, header length
// and the default payload limit.
package udp_tx_csum_engine_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StFold1,
    StFold2,
    StHdrOut,
    StDrain
  } udp_state_e;

  localparam int unsigned UDP_HDR_LEN     = 8;
  localparam int unsigned UDP_MAX_PAYLOAD = 1472;

  // Header words known at header time; length and payload are added once the packet ends.
  function automatic logic [31:0] hdr_seed(input logic [31:0] src_ip,
                                            input logic [31:0] dst_ip,
                                            input logic [7:0]  protocol,
                                            input logic [15:0] src_port,
                                            input logic [15:0] dst_port);
    return {16'h0, src_ip[31:16]} + {16'h0, src_ip[15:0]} +
           {16'h0, dst_ip[31:16]} + {16'h0, dst_ip[15:0]} +
           {24'h0, protocol} + {16'h0, src_port} + {16'h0, dst_port};
  endfunction

endpackage

// File: rtl/udp_payload_fifo.sv
// Synchronous payload FIFO with a write-side mark that can be rewound to drop a packet.
module udp_payload_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 2048
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  input  logic             mark_i,
  input  logic             rewind_i,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  if ((1 << AW) != DEPTH || DEPTH < 2) begin : g_depth_check
    $error("udp_payload_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, rptr_q, mark_q;
  logic             do_write;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o  = (wptr_q == rptr_q);
  assign do_write = wr_en_i && !full_o && !rewind_i;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mark_q <= '0;
    end else begin
      if (rewind_i) begin
        wptr_q <= mark_q;
      end else if (do_write) begin
        wptr_q <= wptr_q + PtrOne;
      end
      if (mark_i) begin
        mark_q <= wptr_q;
      end
      if (rd_en_i && !empty_o) begin
        rptr_q <= rptr_q + PtrOne;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_write) begin
      mem[wptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = mem[rptr_q[AW-1:0]];

endmodule

// File: rtl/udp_tx_csum_engine.sv
// UDP transmit checksum engine: buffers one payload, sums pseudo-header, header and payload,
// then emits the header fields followed by an unaltered replay of the payload.
module udp_tx_csum_engine
  import udp_tx_csum_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned MAX_PAYLOAD = UDP_MAX_PAYLOAD,
  parameter int unsigned FIFO_DEPTH  = 2048
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  s_hdr_tvalid,
  output logic                  s_hdr_trdy,
  input  logic [31:0]           s_hdr_src_ip,
  input  logic [31:0]           s_hdr_dst_ip,
  input  logic [7:0]            s_hdr_protocol,
  input  logic [15:0]           s_hdr_src_port,
  input  logic [15:0]           s_hdr_dst_port,
  input  logic                  s_hdr_csum_en,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_trdy,
  output logic                  m_hdr_tvalid,
  input  logic                  m_hdr_trdy,
  output logic [15:0]           m_hdr_length,
  output logic [15:0]           m_hdr_checksum,
  output logic [15:0]           m_hdr_src_port,
  output logic [15:0]           m_hdr_dst_port,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_trdy,
  output logic                  o_oversize_err
);

  localparam int unsigned FW = DATA_WIDTH + KEEP_WIDTH + 1;

  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64)
  begin : g_width_check
    $error("udp_tx_csum_engine: DATA_WIDTH must be 8, 16, 32 or 64");
  end
  if (KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_keep_check
    $error("udp_tx_csum_engine: KEEP_WIDTH must equal DATA_WIDTH/8");
  end
  if (FIFO_DEPTH * KEEP_WIDTH < MAX_PAYLOAD) begin : g_depth_check
    $error("udp_tx_csum_engine: FIFO_DEPTH*KEEP_WIDTH must cover MAX_PAYLOAD");
  end

  udp_state_e  state_q;
  logic [31:0] acc_q;
  logic [16:0] byte_cnt_q;
  logic [15:0] length_q;
  logic        drop_q, csum_en_q;
  logic [15:0] src_port_q, dst_port_q;
  logic        s_hdr_trdy_q, m_hdr_tvalid_q, oversize_q;
  logic [15:0] m_length_q, m_checksum_q, m_src_port_q, m_dst_port_q;

  logic [31:0] beat_sum;
  logic [16:0] beat_bytes, next_cnt;
  logic [15:0] udp_len, folded, cmp, csum_final;
  logic        hdr_hs, pay_hs, over_now, fifo_full, fifo_empty;
  logic [FW-1:0] fifo_rd;

  assign hdr_hs   = s_hdr_tvalid && s_hdr_trdy_q;
  assign pay_hs   = s_axis_tvalid && s_axis_trdy;
  assign next_cnt = byte_cnt_q + beat_bytes;
  assign over_now = !drop_q && (next_cnt > 17'(MAX_PAYLOAD));
  assign udp_len  = 16'(next_cnt + 17'(UDP_HDR_LEN));

  // Byte weight follows the absolute payload offset: even offsets are the high byte.
  always_comb begin
    beat_sum   = '0;
    beat_bytes = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      if (s_axis_tkeep[i]) begin
        beat_bytes = beat_bytes + 17'd1;
        if (byte_cnt_q[0] == i[0]) begin
          beat_sum = beat_sum + {16'h0, s_axis_tdata[8*i +: 8], 8'h0};
        end else begin
          beat_sum = beat_sum + {24'h0, s_axis_tdata[8*i +: 8]};
        end
      end
    end
  end

  always_comb begin
    folded     = acc_q[15:0] + {15'h0, acc_q[16]};
    cmp        = ~folded;
    csum_final = !csum_en_q ? 16'h0000 : ((cmp == 16'h0000) ? 16'hFFFF : cmp);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= StIdle;
      acc_q          <= '0;
      byte_cnt_q     <= '0;
      length_q       <= '0;
      drop_q         <= 1'b0;
      csum_en_q      <= 1'b0;
      src_port_q     <= '0;
      dst_port_q     <= '0;
      s_hdr_trdy_q   <= 1'b0;
      m_hdr_tvalid_q <= 1'b0;
      oversize_q     <= 1'b0;
      m_length_q     <= '0;
      m_checksum_q   <= '0;
      m_src_port_q   <= '0;
      m_dst_port_q   <= '0;
    end else begin
      oversize_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          s_hdr_trdy_q <= 1'b1;
          if (hdr_hs) begin
            s_hdr_trdy_q <= 1'b0;
            state_q      <= StAccum;
            acc_q        <= hdr_seed(s_hdr_src_ip, s_hdr_dst_ip, s_hdr_protocol,
                                     s_hdr_src_port, s_hdr_dst_port);
            byte_cnt_q   <= '0;
            drop_q       <= 1'b0;
            csum_en_q    <= s_hdr_csum_en;
            src_port_q   <= s_hdr_src_port;
            dst_port_q   <= s_hdr_dst_port;
          end
        end
        StAccum: begin
          if (pay_hs) begin
            if (drop_q || over_now) begin
              oversize_q <= over_now;
              drop_q     <= 1'b1;
              if (s_axis_tlast) begin
                state_q      <= StIdle;
                s_hdr_trdy_q <= 1'b1;
              end
            end else if (s_axis_tlast) begin
              // Length appears twice: once in the pseudo-header, once in the UDP header.
              acc_q      <= acc_q + beat_sum + {15'h0, udp_len, 1'b0};
              byte_cnt_q <= next_cnt;
              length_q   <= udp_len;
              state_q    <= StFold1;
            end else begin
              acc_q      <= acc_q + beat_sum;
              byte_cnt_q <= next_cnt;
            end
          end
        end
        StFold1: begin
          acc_q   <= {15'h0, {1'b0, acc_q[31:16]} + {1'b0, acc_q[15:0]}};
          state_q <= StFold2;
        end
        StFold2: begin
          acc_q          <= {16'h0, folded};
          m_checksum_q   <= csum_final;
          m_length_q     <= length_q;
          m_src_port_q   <= src_port_q;
          m_dst_port_q   <= dst_port_q;
          m_hdr_tvalid_q <= 1'b1;
          state_q        <= StHdrOut;
        end
        StHdrOut: begin
          if (m_hdr_trdy) begin
            m_hdr_tvalid_q <= 1'b0;
            state_q        <= StDrain;
          end
        end
        StDrain: begin
          if (m_axis_tvalid && m_axis_trdy && m_axis_tlast) begin
            state_q      <= StIdle;
            s_hdr_trdy_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  udp_payload_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .wr_en_i   (pay_hs && !drop_q && !over_now),
    .wr_data_i ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .rd_en_i   (m_axis_tvalid && m_axis_trdy),
    .rd_data_o (fifo_rd),
    .mark_i    (hdr_hs),
    .rewind_i  (pay_hs && over_now),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign s_hdr_trdy     = s_hdr_trdy_q;
  assign s_axis_trdy    = (state_q == StAccum) && !fifo_full;
  assign m_hdr_tvalid   = m_hdr_tvalid_q;
  assign m_hdr_length   = m_length_q;
  assign m_hdr_checksum = m_checksum_q;
  assign m_hdr_src_port = m_src_port_q;
  assign m_hdr_dst_port = m_dst_port_q;
  assign o_oversize_err = oversize_q;

  // Output lanes read as zero outside a valid beat.
  assign m_axis_tvalid = (state_q == StDrain) && !fifo_empty;
  assign m_axis_tdata  = m_axis_tvalid ? fifo_rd[DATA_WIDTH-1:0] : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? fifo_rd[DATA_WIDTH +: KEEP_WIDTH] : '0;
  assign m_axis_tlast  = m_axis_tvalid && fifo_rd[FW-1];

endmodule
